// File: rtl/dma_unpack_fifo_if.sv
// Handshake bundle between the DMA write side and the register read path.
// master: DMA/reader side (drives data and ready); slave: the FIFO itself.
interface dma_unpack_fifo_if #(
  parameter int DATA_WIDTH = 96,
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                  flush;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [WORD_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic                  full;
  logic                  empty;
  logic [LW-1:0]         level;
  logic                  overflow;

  modport master (
    output flush,
    output wr_valid,
    output wr_data,
    output rd_ready,
    input  wr_ready,
    input  rd_valid,
    input  rd_data,
    input  rd_last,
    input  full,
    input  empty,
    input  level,
    input  overflow
  );

  modport slave (
    input  flush,
    input  wr_valid,
    input  wr_data,
    input  rd_ready,
    output wr_ready,
    output rd_valid,
    output rd_data,
    output rd_last,
    output full,
    output empty,
    output level,
    output overflow
  );
endinterface

// File: rtl/dma_unpack_fifo.sv
// Element FIFO that serialises each 96-bit DMA element into three 32-bit
// words, low word first. Ports: clk, rst (async high), bus (slave modport).
module dma_unpack_fifo #(
  parameter int DATA_WIDTH = 96,
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input logic              clk,
  input logic              rst,
  dma_unpack_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (DATA_WIDTH != 3 * WORD_WIDTH) begin : g_chk_w
    $error("DATA_WIDTH must be 3*WORD_WIDTH");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_d
    $error("DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    W2 = 2'd2
  } word_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  word_e         word_q, word_d;
  logic          ovf_q, ovf_d;

  logic                  full_w;
  logic                  empty_w;
  logic                  push_w;
  logic                  rd_hs_w;
  logic                  pop_w;
  logic [DATA_WIDTH-1:0] head_w;
  logic [WORD_WIDTH-1:0] word_w;

  assign full_w  = (count_q == LW'(DEPTH));
  assign empty_w = (count_q == '0);

  // Full blocks writes even if the head pops this cycle.
  assign push_w  = bus.wr_valid && !full_w;
  assign rd_hs_w = bus.rd_ready && !empty_w;
  assign pop_w   = rd_hs_w && (word_q == W2);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    word_d   = word_q;
    ovf_d    = ovf_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      word_d   = W0;
      ovf_d    = 1'b0;
    end else begin
      if (push_w) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_w) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case (1'b1)
        push_w && !pop_w: count_d = count_q + LW'(1);
        pop_w && !push_w: count_d = count_q - LW'(1);
        default:          count_d = count_q;
      endcase
      if (rd_hs_w) begin
        unique case (word_q)
          W0:      word_d = W1;
          W1:      word_d = W2;
          W2:      word_d = W0;
          default: word_d = W0;
        endcase
      end
      if (bus.wr_valid && full_w) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      word_q   <= W0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      word_q   <= word_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_w && !bus.flush) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign head_w = mem_q[rd_ptr_q];

  always_comb begin
    word_w = '0;
    if (!empty_w) begin
      unique case (word_q)
        W0:      word_w = head_w[WORD_WIDTH-1:0];
        W1:      word_w = head_w[2*WORD_WIDTH-1:WORD_WIDTH];
        W2:      word_w = head_w[3*WORD_WIDTH-1:2*WORD_WIDTH];
        default: word_w = '0;
      endcase
    end
  end

  assign bus.wr_ready = !full_w;
  assign bus.rd_valid = !empty_w;
  assign bus.rd_data  = word_w;
  assign bus.rd_last  = !empty_w && (word_q == W2);
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.level    = count_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_dma_unpack_fifo.sv
// Scoreboarded bench for dma_unpack_fifo: directed element pushes,
// a negedge monitor compares every word handshake against a queue.
module tb_dma_unpack_fifo;
  logic clk;
  logic rst;

  dma_unpack_fifo_if #(
    .DATA_WIDTH(96),
    .WORD_WIDTH(32),
    .DEPTH(16)
  ) bus ();

  dma_unpack_fifo #(
    .DATA_WIDTH(96),
    .WORD_WIDTH(32),
    .DEPTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [32:0] sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [95:0] mk(input logic [31:0] b);
    return {b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic sb_push(input logic [95:0] d);
    sb_q.push_back({1'b0, d[31:0]});
    sb_q.push_back({1'b0, d[63:32]});
    sb_q.push_back({1'b1, d[95:64]});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, 96'(bus.empty), 96'd1);
    chk({tag, "_full"}, 96'(bus.full), 96'd0);
    chk({tag, "_wr_ready"}, 96'(bus.wr_ready), 96'd1);
    chk({tag, "_rd_valid"}, 96'(bus.rd_valid), 96'd0);
    chk({tag, "_rd_last"}, 96'(bus.rd_last), 96'd0);
    chk({tag, "_level"}, 96'(bus.level), 96'd0);
    chk({tag, "_rd_data"}, 96'(bus.rd_data), 96'd0);
    chk({tag, "_overflow"}, 96'(bus.overflow), 96'd0);
  endtask

  // Monitor: every accepted word must match the queue head.
  always @(negedge clk) begin
    if (!rst && bus.rd_valid && bus.rd_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none",
                 bus.rd_data);
      end else begin
        chk("rd_word", 96'({bus.rd_last, bus.rd_data}),
            96'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [95:0] f_el;

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    bus.rd_ready = 1'b0;
    #2;
    chk_reset_vals("rst");
    #10;
    rst = 1'b0;

    // Single element, reader always ready.
    step(1);
    bus.wr_valid = 1'b1;
    bus.wr_data = 96'h0000000C_0000000B_0000000A;
    sb_push(bus.wr_data);
    step(1);
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    step(4);
    chk("t1_empty", 96'(bus.empty), 96'd1);

    // Fill to full, overflow attempt, drain across the wrap.
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data = mk(32'h100 + 32'(i) * 32'h10);
      sb_push(bus.wr_data);
      step(1);
    end
    chk("t2_full", 96'(bus.full), 96'd1);
    chk("t2_level", 96'(bus.level), 96'd16);
    chk("t2_wr_ready", 96'(bus.wr_ready), 96'd0);
    chk("t2_ovf_pre", 96'(bus.overflow), 96'd0);
    bus.wr_data = 96'hDEAD_BEEF_F00D;
    step(1);
    chk("t2_ovf", 96'(bus.overflow), 96'd1);
    chk("t2_level_ovf", 96'(bus.level), 96'd16);
    chk("t2_head", 96'(bus.rd_data), 96'h100);
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    step(48);
    chk("t2_empty", 96'(bus.empty), 96'd1);

    // Simultaneous push and element pop at level 5.
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data = mk(32'h500 + 32'(i) * 32'h10);
      sb_push(bus.wr_data);
      step(1);
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    step(2);
    chk("t3_level_pre", 96'(bus.level), 96'd5);
    chk("t3_last_pre", 96'(bus.rd_last), 96'd1);
    bus.wr_valid = 1'b1;
    bus.wr_data = mk(32'h550);
    sb_push(bus.wr_data);
    step(1);
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    chk("t3_level", 96'(bus.level), 96'd5);
    chk("t3_next_w0", 96'(bus.rd_data), 96'h510);
    chk("t3_next_last", 96'(bus.rd_last), 96'd0);
    bus.rd_ready = 1'b1;
    step(15);
    chk("t3_empty", 96'(bus.empty), 96'd1);

    // Stall after word 0, then flush with a competing write.
    bus.rd_ready = 1'b0;
    f_el = 96'h33333333_22222222_11111111;
    bus.wr_valid = 1'b1;
    bus.wr_data = f_el;
    sb_push(f_el);
    step(1);
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    step(1);
    bus.rd_ready = 1'b0;
    chk("t4_ovf_sticky", 96'(bus.overflow), 96'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t4_stall_data", 96'(bus.rd_data), 96'h22222222);
      chk("t4_stall_last", 96'(bus.rd_last), 96'd0);
      step(1);
    end
    bus.flush = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data = 96'h77777777_66666666_55555555;
    step(1);
    bus.flush = 1'b0;
    bus.wr_valid = 1'b0;
    sb_q.delete();
    chk("t4_level", 96'(bus.level), 96'd0);
    chk("t4_empty", 96'(bus.empty), 96'd1);
    chk("t4_ovf", 96'(bus.overflow), 96'd0);
    step(3);
    chk("t4_no_write", 96'(bus.rd_valid), 96'd0);

    // Async reset while the head sits at word 1.
    bus.wr_valid = 1'b1;
    bus.wr_data = 96'h99999999_88888888_AAAAAAAA;
    sb_push(bus.wr_data);
    step(1);
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    step(1);
    bus.rd_ready = 1'b0;
    chk("t5_w1", 96'(bus.rd_data), 96'h88888888);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_vals("t5");
    sb_q.delete();
    #2;
    rst = 1'b0;
    step(1);
    bus.wr_valid = 1'b1;
    bus.rd_ready = 1'b1;
    bus.wr_data = {32'h3, 32'h2, 32'h1};
    sb_push(bus.wr_data);
    step(1);
    bus.wr_valid = 1'b0;
    step(5);
    chk("sb_drained", 96'(sb_q.size()), 96'd0);
    chk("end_empty", 96'(bus.empty), 96'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dma_unpack_fifo.md
Name: dma_unpack_fifo

Overview:
- Receive-side counterpart of the DMA packing FIFO: buffers 96-bit elements delivered by the DMA controller.
- Serialises each element into three 32-bit words for the register/bus reader.
- Word order matches the packer's {w2,w1,w0} layout: bits [31:0] are returned first.
- Sits between dma_controller (write side) and the peripheral register read path.

Parameters:
- DATA_WIDTH, 96, element width; must equal 3*WORD_WIDTH.
- WORD_WIDTH, 32, output word width.
- DEPTH, 16, element slots; power of two, >=2.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of contents and state
- wr_valid  input  1  DMA offers wr_data
- wr_ready  output  1  FIFO can accept an element (= !full)
- wr_data  input  DATA_WIDTH  96-bit element
- rd_valid  output  1  rd_data holds a valid word
- rd_ready  input  1  reader consumes the word
- rd_data  output  WORD_WIDTH  current word of head element
- rd_last  output  1  rd_data is word 2 of the element
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- level  output  $clog2(DEPTH)+1  elements stored
- overflow  output  1  sticky: wr_valid seen while full

Behaviour:
- Reset (async):
  - wr_ptr, rd_ptr, count, word_idx <= 0; overflow <= 0.
  - Outputs after reset: empty=1, full=0, wr_ready=1, rd_valid=0, rd_last=0, level=0, rd_data=0.
  - Memory contents are not reset.
- Push:
  - Occurs when wr_valid && wr_ready.
  - mem[wr_ptr] <= wr_data; wr_ptr increments, wrapping DEPTH-1 -> 0.
- Read word FSM (word_idx):
  - States: W0 -> W1 -> W2 -> W0.
  - rd_data = mem[rd_ptr][word_idx*32 +: 32] when rd_valid, else 0.
  - rd_valid = !empty; rd_last = rd_valid && (word_idx == W2).
  - A word handshake (rd_valid && rd_ready) advances word_idx.
  - A handshake in W2 pops the element: rd_ptr increments (wrapping) and word_idx returns to W0.
  - Handshakes in W0/W1 do not change count.
- Latency:
  - First-word fall-through.
  - An element pushed at edge N gives rd_valid=1 with word 0 in the cycle after edge N, when the FIFO was empty.
- Count:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged, both pointers advance.
- Full:
  - wr_ready=0. A pop in the same cycle does NOT enable a push; the slot frees on the next cycle.
  - wr_valid while full sets overflow=1. The element is dropped and no state changes.
- Empty:
  - rd_valid=0 and rd_ready is ignored; word_idx holds at W0.
- Reader stalls:
  - With rd_ready=0 and rd_valid=1, rd_data and rd_last stay stable.
- Flush:
  - Takes priority over push/pop in the same cycle.
  - Clears pointers, count, word_idx and overflow. Any partially read element is discarded.
- Reset mid-element:
  - Any partially read element is lost; the next element read starts at W0.
- level = count; full and empty are decoded from count, not from pointer compare.

Test Plan:
- Reset, then push 96'h0000000C_0000000B_0000000A with rd_ready=1:
  - rd_data reads 32'hA, 32'hB, 32'hC on consecutive cycles.
  - rd_last is 1 only with 32'hC.
  - empty=1 afterwards.
- Push 16 elements with rd_ready=0:
  - full=1, level=16, wr_ready=0.
  - A 17th wr_valid sets overflow=1 and contents are unchanged.
  - Then drain 48 words in order across the pointer wrap.
- At level=5 with head at W2, assert wr_valid and rd_ready together:
  - level stays 5; the next element's word 0 appears the following cycle.
- Read word 0 of the head, stall rd_ready=0 for 4 cycles, then assert flush together with wr_valid:
  - rd_data is stable during the stall.
  - After the flush, level=0, empty=1, overflow=0, and no element is written.
- Assert rst asynchronously between clock edges while word_idx=W1:
  - Outputs go to reset values immediately.
  - A subsequent push of 96'h3_2_1 reads 1, 2, 3.
